updown_mod_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_prescaler.sv | 44 ++++
 rtl/updown_mod_counter.sv | 116 +++++++++++
 tb/tb_updown_mod_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Direction and mode encodings, plus the prescaler phase width.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Phase register width; a one-bit floor keeps PRESCALE==1 legal.
    function automatic int phase_w(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-tick generator: one tick every PRESCALE enabled cycles.
// PRESCALE==1 passes en straight through as the tick.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = phase_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign tick = (PRESCALE == 1) ? en : (en && (phase_q == LAST));

    // Next phase: advance while enabled, wrap on tick, hold when idle.
    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (tick) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Phase register; reset and load both discard partial progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with load, wrap/saturate, flags.
// Optional count capture port pair under COUNTER_CAPTURE_EN.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat_hit
`ifdef COUNTER_CAPTURE_EN
    ,
    input  logic             capture,
    output logic [WIDTH-1:0] cap_count
`endif
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             sat_hit_q;
    logic             sat_hit_d;
    logic [WIDTH-1:0] ld_clip;
    dir_e             dir;
    mode_e            mode;

    assign dir     = dir_e'(up);
    assign mode    = mode_e'(sat);
    assign ld_clip = (load_val > MAX_W) ? MAX_W : load_val;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (en),
        .tick (tick)
    );

    // Next count and boundary flags: load beats step beats hold.
    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        sat_hit_d = 1'b0;
        if (load) begin
            count_d = ld_clip;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (count_q < MAX_W) begin
                    count_d = count_q + WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    sat_hit_d = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    count_d = MAX_W;
                    tc_d    = 1'b1;
                end else begin
                    sat_hit_d = 1'b1;
                end
            end
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign sat_hit = sat_hit_q;

`ifdef COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q;

    // Snapshot of the pre-update count on a capture strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= '0;
        end else if (capture) begin
            cap_q <= count_q;
        end
    end

    assign cap_count = cap_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench: modulo-10 counter, PRESCALE 1 and 3.
// Capture checks run only when COUNTER_CAPTURE_EN is defined.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset_a, en_a, load_a;
    logic       reset_b, en_b, load_b;
    logic       up, sat;
    logic [3:0] load_val;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, sh_a, sh_b;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef COUNTER_CAPTURE_EN
    logic       cap_a, cap_b;
    logic [3:0] capc_a, capc_b;
`endif

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .up(up), .sat(sat),
        .load(load_a), .load_val(load_val),
        .count(count_a), .tc(tc_a), .sat_hit(sh_a)
`ifdef COUNTER_CAPTURE_EN
        , .capture(cap_a), .cap_count(capc_a)
`endif
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .up(up), .sat(sat),
        .load(load_b), .load_val(load_val),
        .count(count_b), .tc(tc_b), .sat_hit(sh_b)
`ifdef COUNTER_CAPTURE_EN
        , .capture(cap_b), .cap_count(capc_b)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] c,
                         input logic t, input logic s);
        chk({tag, ".count"}, count_a, c);
        chk({tag, ".tc"}, {3'b0, tc_a}, {3'b0, t});
        chk({tag, ".sat_hit"}, {3'b0, sh_a}, {3'b0, s});
    endtask

    initial begin
        reset_a = 1; en_a = 0; load_a = 0;
        reset_b = 1; en_b = 0; load_b = 0;
        up = 1; sat = 0; load_val = 0;
`ifdef COUNTER_CAPTURE_EN
        cap_a = 0; cap_b = 0;
`endif
        cyc(); cyc();
        chk_a("reset", 4'd0, 0, 0);
        chk("reset_b.count", count_b, 4'd0);

        // Count up through the wrap.
        reset_a = 0; en_a = 1; up = 1; sat = 0;
        for (int i = 1; i <= 11; i++) begin
            cyc();
            chk_a($sformatf("up%0d", i), 4'(i % 10), i == 10, 0);
        end

        // Load 2 then count down through the wrap.
        load_a = 1; load_val = 2; cyc();
        chk_a("load2", 4'd2, 0, 0);
        load_a = 0; up = 0;
        cyc(); chk_a("dn1", 4'd1, 0, 0);
        cyc(); chk_a("dn0", 4'd0, 0, 0);
        cyc(); chk_a("dnwrap", 4'd9, 1, 0);
        cyc(); chk_a("dn8", 4'd8, 0, 0);

        // Saturate at the top.
        sat = 1; load_a = 1; load_val = 8; cyc();
        chk_a("satld8", 4'd8, 0, 0);
        load_a = 0; up = 1;
        cyc(); chk_a("sat9", 4'd9, 0, 0);
        cyc(); chk_a("sathold1", 4'd9, 0, 1);
        cyc(); chk_a("sathold2", 4'd9, 0, 1);
        up = 0;
        cyc(); chk_a("satdn8", 4'd8, 0, 0);

        // Saturate at zero, then hold with en low.
        load_a = 1; load_val = 0; cyc();
        load_a = 0;
        cyc(); chk_a("satlo", 4'd0, 0, 1);
        en_a = 0;
        cyc(); chk_a("idle", 4'd0, 0, 0);

        // Load clipping and priorities.
        sat = 0; en_a = 1; up = 1;
        load_a = 1; load_val = 12; cyc();
        chk_a("clip", 4'd9, 0, 0);
        reset_a = 1; load_val = 5; cyc();
        chk_a("rst_over_load", 4'd0, 0, 0);
        reset_a = 0; cyc();
        chk_a("load_over_step", 4'd5, 0, 0);
        load_a = 0; cyc();
        chk_a("post_load", 4'd6, 0, 0);

        // Reset clears a pending tc flag.
        load_a = 1; load_val = 9; cyc();
        load_a = 0; cyc();
        chk_a("tc_pre", 4'd0, 1, 0);
        reset_a = 1; cyc();
        chk_a("rst_tc", 4'd0, 0, 0);
        reset_a = 0;

`ifdef COUNTER_CAPTURE_EN
        load_a = 1; load_val = 7; cyc();
        load_a = 0; cap_a = 1; cyc();
        chk("cap7", capc_a, 4'd7);
        chk("cap_cnt8", count_a, 4'd8);
        cap_a = 0; cyc();
        chk("cap_hold", capc_a, 4'd7);
        chk("cap_cnt9", count_a, 4'd9);
`endif
        en_a = 0;

        // Prescaled instance: step every third enabled cycle.
        reset_b = 0; en_b = 1; up = 1; sat = 0;
        cyc(); chk("ps_e1", count_b, 4'd0);
        cyc(); chk("ps_e2", count_b, 4'd0);
        cyc(); chk("ps_e3", count_b, 4'd1);
        cyc(); chk("ps_e4", count_b, 4'd1);
        cyc(); chk("ps_e5", count_b, 4'd1);
        cyc(); chk("ps_e6", count_b, 4'd2);
        cyc(); chk("ps_e7", count_b, 4'd2);
        en_b = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("ps_hold", count_b, 4'd2);
        en_b = 1;
        cyc(); chk("ps_re1", count_b, 4'd2);
        cyc(); chk("ps_re2", count_b, 4'd3);

        // Reset mid-prescale discards the phase.
        cyc();
        reset_b = 1; cyc();
        chk("ps_rst", count_b, 4'd0);
        chk("ps_rst_tc", {3'b0, tc_b}, 4'd0);
        reset_b = 0;
        cyc(); chk("ps_r1", count_b, 4'd0);
        cyc(); chk("ps_r2", count_b, 4'd0);
        cyc(); chk("ps_r3", count_b, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
